// File: rtl/decode_stage.sv
// RV32I decode pipeline stage. It registers the control bundle and immediate behind a valid/ready
// handshake, and it stalls on load-use hazards, handles flush, and flags illegal encodings.
`ifndef ALU_ADD
`define ALU_ADD               4'd0
`define ALU_SUB               4'd1
`define ALU_SLL               4'd2
`define ALU_SLT               4'd3
`define ALU_SLTU              4'd4
`define ALU_XOR               4'd5
`define ALU_SRL               4'd6
`define ALU_SRA               4'd7
`define ALU_OR                4'd8
`define ALU_AND               4'd9
`define RF_WDATA_SEL_ALU      2'd0
`define RF_WDATA_SEL_DM       2'd1
`define RF_WDATA_SEL_PC       2'd2
`define ALU_OP1_SEL_REG       1'b0
`define ALU_OP1_SEL_PC        1'b1
`define ALU_OP2_SEL_REG       1'b0
`define ALU_OP2_SEL_IMM       1'b1
`define CSR_SEL_REG           1'b0
`define CSR_SEL_IMM           1'b1
`endif

module decode_stage #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int HAZARD_BUBBLES = 1,
  parameter int ENABLE_CSR     = 1,
  localparam int RSEL_W        = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   imm,
  output logic [RSEL_W-1:0] rf_rsel1,
  output logic [RSEL_W-1:0] rf_rsel2,
  output logic [RSEL_W-1:0] rf_wsel,
  output logic              rf_wen,
  output logic              dm_wen,
  output logic [1:0]        rf_wdata_sel,
  output logic              alu_op1_sel,
  output logic              alu_op2_sel,
  output logic [3:0]        alu_operation,
  output logic [2:0]        branch_condition,
  output logic              is_branch,
  output logic              is_jal,
  output logic              is_jalr,
  output logic              csr_sel,
  output logic              csr_wen,
  output logic              return_from_interrupt,
  output logic              illegal
);

  localparam int CNT_W = (HAZARD_BUBBLES > 0) ? $clog2(HAZARD_BUBBLES + 1) : 1;
  localparam bit CSR_ON = (ENABLE_CSR != 0);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [RSEL_W-1:0] rsel1;
    logic [RSEL_W-1:0] rsel2;
    logic [RSEL_W-1:0] wsel;
    logic              rf_wen;
    logic              dm_wen;
    logic [1:0]        wdata_sel;
    logic              op1_sel;
    logic              op2_sel;
    logic [3:0]        alu_op;
    logic [2:0]        bcond;
    logic              is_branch;
    logic              is_jal;
    logic              is_jalr;
    logic              csr_sel;
    logic              csr_wen;
    logic              rfi;
    logic              illegal;
    logic              is_load;
  } bundle_t;

  bundle_t          r_b;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_op, w_fence, w_sys;
  logic        w_sys_csr, w_mret, w_known, w_ill;
  logic        w_rd_rs1, w_rd_rs2, w_wr_rd;
  logic [RSEL_W-1:0] w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm32;
  logic [3:0]  w_alu;
  bundle_t     w_dec;
  logic        w_detect, w_stall, w_xfer;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];
  assign w_rs1 = in_instr[15 +: RSEL_W];
  assign w_rs2 = in_instr[20 +: RSEL_W];
  assign w_rd  = in_instr[7 +: RSEL_W];

  assign w_lui   = (w_opc == 7'b0110111);
  assign w_auipc = (w_opc == 7'b0010111);
  assign w_jal   = (w_opc == 7'b1101111);
  assign w_jalr  = (w_opc == 7'b1100111);
  assign w_br    = (w_opc == 7'b1100011);
  assign w_ld    = (w_opc == 7'b0000011);
  assign w_st    = (w_opc == 7'b0100011);
  assign w_opi   = (w_opc == 7'b0010011);
  assign w_op    = (w_opc == 7'b0110011);
  assign w_fence = (w_opc == 7'b0001111);
  assign w_sys   = (w_opc == 7'b1110011);

  assign w_sys_csr = w_sys & (w_f3 != 3'b000);
  assign w_mret    = w_sys & (w_f3 == 3'b000) & (in_instr[31:20] == 12'h302);
  assign w_known   = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st |
                     w_opi | w_op | w_fence | w_sys;

  // funct7=0x20 is only meaningful for SUB and SRA among the R-type ops.
  assign w_ill = !w_known
               | (w_op & (w_f7 != 7'h00) & (w_f7 != 7'h20))
               | (w_op & (w_f7 == 7'h20) & (w_f3 != 3'b000) & (w_f3 != 3'b101))
               | (w_br & ((w_f3 == 3'b010) | (w_f3 == 3'b011)))
               | (w_sys & !CSR_ON & !w_mret);

  assign w_rd_rs1 = w_jalr | w_br | w_ld | w_st | w_opi | w_op | (w_sys_csr & !w_f3[2]);
  assign w_rd_rs2 = w_br | w_st | w_op;
  assign w_wr_rd  = w_op | w_opi | w_ld | w_lui | w_auipc | w_jal | w_jalr | (w_sys_csr & CSR_ON);

  always_comb begin
    w_imm32 = 32'd0;
    if (w_opi | w_ld | w_jalr | w_sys) w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    else if (w_st)  w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    else if (w_br)  w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
    else if (w_lui | w_auipc) w_imm32 = {in_instr[31:12], 12'd0};
    else if (w_jal) w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
  end

  always_comb begin
    w_alu = `ALU_ADD;
    if (w_op | w_opi) begin
      case (w_f3)
        3'b000:  w_alu = (w_op & in_instr[30]) ? `ALU_SUB : `ALU_ADD;
        3'b001:  w_alu = `ALU_SLL;
        3'b010:  w_alu = `ALU_SLT;
        3'b011:  w_alu = `ALU_SLTU;
        3'b100:  w_alu = `ALU_XOR;
        3'b101:  w_alu = in_instr[30] ? `ALU_SRA : `ALU_SRL;
        3'b110:  w_alu = `ALU_OR;
        default: w_alu = `ALU_AND;
      endcase
    end
  end

  always_comb begin
    w_dec           = '0;
    w_dec.pc        = in_pc;
    w_dec.imm       = XLEN'($signed(w_imm32));
    w_dec.rsel1     = w_rd_rs1 ? w_rs1 : '0;
    w_dec.rsel2     = w_rd_rs2 ? w_rs2 : '0;
    w_dec.wsel      = w_wr_rd ? w_rd : '0;
    w_dec.rf_wen    = w_wr_rd & (w_rd != '0) & !w_ill;
    w_dec.dm_wen    = w_st & !w_ill;
    w_dec.wdata_sel = (w_jal | w_jalr) ? `RF_WDATA_SEL_PC :
                      w_ld             ? `RF_WDATA_SEL_DM : `RF_WDATA_SEL_ALU;
    w_dec.op1_sel   = (w_auipc | w_jal | w_br) ? `ALU_OP1_SEL_PC : `ALU_OP1_SEL_REG;
    w_dec.op2_sel   = w_op ? `ALU_OP2_SEL_REG : `ALU_OP2_SEL_IMM;
    w_dec.alu_op    = w_alu;
    w_dec.bcond     = w_br ? w_f3 : 3'b000;
    w_dec.is_branch = w_br;
    w_dec.is_jal    = w_jal;
    w_dec.is_jalr   = w_jalr;
    w_dec.csr_sel   = (w_sys_csr & w_f3[2]) ? `CSR_SEL_IMM : `CSR_SEL_REG;
    w_dec.csr_wen   = w_sys_csr & CSR_ON & !w_ill;
    w_dec.rfi       = w_mret;
    w_dec.illegal   = w_ill;
    w_dec.is_load   = w_ld;
  end

  // The detection cycle itself is the first stall cycle, so the counter only covers the rest.
  assign w_detect = (HAZARD_BUBBLES != 0) & r_valid & r_b.is_load & (r_b.wsel != '0) & in_valid &
                    ((w_rd_rs1 & (w_rs1 == r_b.wsel)) | (w_rd_rs2 & (w_rs2 == r_b.wsel)));
  assign w_stall  = w_detect | (r_cnt != '0);
  assign in_ready = (!r_valid | out_ready) & !w_stall;
  assign w_xfer   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_cnt       <= '0;
      r_b         <= '0;
      r_b.alu_op  <= `ALU_ADD;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_b     <= w_dec;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_detect)           r_cnt <= CNT_W'(HAZARD_BUBBLES - 1);
      else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
    end
  end

  assign out_valid             = r_valid;
  assign out_pc                = r_b.pc;
  assign imm                   = r_b.imm;
  assign rf_rsel1              = r_b.rsel1;
  assign rf_rsel2              = r_b.rsel2;
  assign rf_wsel               = r_b.wsel;
  assign rf_wen                = r_b.rf_wen;
  assign dm_wen                = r_b.dm_wen;
  assign rf_wdata_sel          = r_b.wdata_sel;
  assign alu_op1_sel           = r_b.op1_sel;
  assign alu_op2_sel           = r_b.op2_sel;
  assign alu_operation         = r_b.alu_op;
  assign branch_condition      = r_b.bcond;
  assign is_branch             = r_b.is_branch;
  assign is_jal                = r_b.is_jal;
  assign is_jalr               = r_b.is_jalr;
  assign csr_sel               = r_b.csr_sel;
  assign csr_wen               = r_b.csr_wen;
  assign return_from_interrupt = r_b.rfi;
  assign illegal               = r_b.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the stimulus pushes hand-decoded bundles, and a negedge monitor checks them.
module tb_decode_stage;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SRA = 4'd7;
  localparam logic [1:0] WD_DM = 2'd1, WD_PC = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, wsel;
    logic        rf_wen, dm_wen;
    logic [1:0]  wdsel;
    logic        op1, op2;
    logic [3:0]  alu;
    logic [2:0]  bcond;
    logic        isb, isjal, isjalr, csel, cwen, rfi, ill;
  } exp_t;

  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid, rf_wen, dm_wen, alu_op1_sel, alu_op2_sel;
  logic is_branch, is_jal, is_jalr, csr_sel, csr_wen, return_from_interrupt, illegal;
  logic [31:0] out_pc, imm;
  logic [4:0]  rf_rsel1, rf_rsel2, rf_wsel;
  logic [1:0]  rf_wdata_sel;
  logic [3:0]  alu_operation;
  logic [2:0]  branch_condition;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .imm(imm), .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2), .rf_wsel(rf_wsel), .rf_wen(rf_wen),
    .dm_wen(dm_wen), .rf_wdata_sel(rf_wdata_sel), .alu_op1_sel(alu_op1_sel),
    .alu_op2_sel(alu_op2_sel), .alu_operation(alu_operation), .branch_condition(branch_condition),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .csr_sel(csr_sel),
    .csr_wen(csr_wen), .return_from_interrupt(return_from_interrupt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  exp_t q[$];
  exp_t got;

  assign got = {out_pc, imm, rf_rsel1, rf_rsel2, rf_wsel, rf_wen, dm_wen, rf_wdata_sel,
                alu_op1_sel, alu_op2_sel, alu_operation, branch_condition, is_branch, is_jal,
                is_jalr, csr_sel, csr_wen, return_from_interrupt, illegal};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Compared on every valid cycle, so a held bundle is checked for stability too.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: pc %0h with empty scoreboard", out_pc);
      end else begin
        if (got !== q[0]) begin
          fails++;
          $display("FAIL bundle pc=%0h: got %0h, expected %0h", q[0].pc, got, q[0]);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  function automatic exp_t base(input logic [31:0] pc);
    exp_t e;
    e     = '0;
    e.pc  = pc;
    e.op2 = 1'b1;
    e.alu = ADD;
    return e;
  endfunction

  task automatic send(input logic [31:0] ins, input exp_t e);
    int n;
    q.push_back(e);
    in_valid = 1; in_instr = ins; in_pc = e.pc;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_alu", 64'(alu_operation), 64'(ADD));
    chk("rst_rfwen", 64'(rf_wen), 0);
    chk("rst_imm", 64'(imm), 0);
    chk("rst_illegal", 64'(illegal), 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 1);
    @(posedge clk); #1;

    e = base(32'h100); e.imm = 5; e.wsel = 1; e.rf_wen = 1;                 send(32'h00500093, e);
    e = base(32'h104); e.rs1 = 1; e.wsel = 2; e.rf_wen = 1; e.wdsel = WD_DM; send(32'h0000A103, e);

    // add x3,x2,x1 directly behind lw x2: one stall cycle, then one bubble.
    e = base(32'h108); e.rs1 = 2; e.rs2 = 1; e.wsel = 3; e.rf_wen = 1; e.op2 = 0;
    q.push_back(e);
    in_valid = 1; in_instr = 32'h001101B3; in_pc = 32'h108;
    @(negedge clk); chk("hz_stall", 64'(in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("hz_bubble", 64'(out_valid), 0); chk("hz_resume", 64'(in_ready), 1);
    @(posedge clk); #1 in_valid = 0;

    e = base(32'h10C); e.rs1 = 1; e.rs2 = 2; e.wsel = 3; e.rf_wen = 1; e.op2 = 0; e.alu = SUB;
    send(32'h402081B3, e);
    e = base(32'h110); e.rs1 = 6; e.wsel = 5; e.rf_wen = 1; e.alu = SRA; e.imm = 32'h403;
    send(32'h40335293, e);
    e = base(32'h114); e.rs1 = 2; e.wsel = 1; e.rf_wen = 1; e.wdsel = WD_PC; e.isjalr = 1;
    send(32'h000100E7, e);
    e = base(32'h118); e.rs1 = 1; e.rs2 = 2; e.dm_wen = 1; e.imm = 4;        send(32'h0020A223, e);
    e = base(32'h11C); e.wsel = 5; e.rf_wen = 1; e.imm = 32'h12345000;       send(32'h123452B7, e);
    e = base(32'h120); e.wsel = 1; e.rf_wen = 1; e.wdsel = WD_PC; e.op1 = 1; e.isjal = 1; e.imm = 8;
    send(32'h008000EF, e);
    e = base(32'h124); e.wsel = 1; e.rf_wen = 1; e.imm = 32'hFFFFFFFF;       send(32'hFFF00093, e);
    e = base(32'h128); e.op2 = 1; e.ill = 1;                                 send(32'h00000000, e);
    e = base(32'h12C); e.op1 = 1; e.isb = 1; e.bcond = 3'b011; e.ill = 1;    send(32'h00003063, e);
    e = base(32'h130);                                                       send(32'h00000013, e);

    // MRET held under back-pressure.
    repeat (2) @(posedge clk); #1 out_ready = 0;
    e = base(32'h134); e.imm = 32'h302; e.rfi = 1;                           send(32'h30200073, e);
    repeat (3) begin @(negedge clk); chk("hold_in_ready", 64'(in_ready), 0); end
    @(posedge clk); #1 out_ready = 1;

    // Flush overrides a transfer that would otherwise be accepted.
    repeat (2) @(posedge clk); #1;
    in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h140; flush = 1;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk); chk("flush_xfer_drop", 64'(out_valid), 0);

    // Flush during a load-use stall.
    @(posedge clk); #1;
    e = base(32'h200); e.rs1 = 1; e.wsel = 2; e.rf_wen = 1; e.wdsel = WD_DM; send(32'h0000A103, e);
    in_valid = 1; in_instr = 32'h001101B3; in_pc = 32'h204; flush = 1;
    @(negedge clk); chk("flush_stall", 64'(in_ready), 0);
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk); chk("flush_valid", 64'(out_valid), 0); chk("flush_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    e = base(32'h300); e.imm = 5; e.wsel = 1; e.rf_wen = 1;                 send(32'h00500093, e);

    n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("drain", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
